// File: rtl/conv_mult_dispatcher.sv
// Dispatches (filter,row,col) convolution jobs onto a pool of NMULT MAC units and tracks unit occupancy.
// Optional macro DISPATCH_RR_EN: round-robin grant pointer instead of fixed lowest-index priority.
module conv_mult_dispatcher #(
    parameter int NMULT    = 64,
    parameter int UNIT_W   = 6,
    parameter int OUT_SIZE = 30,
    parameter int NF       = 3,
    parameter int CRD_W    = 5,
    parameter int FLT_W    = 2,
    parameter int CNT_W    = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NMULT-1:0]  unit_disable,
    input  logic [NMULT-1:0]  unit_done,
    input  logic              job_ready,
    output logic              job_valid,
    output logic [UNIT_W-1:0] job_unit,
    output logic [CRD_W-1:0]  job_row,
    output logic [CRD_W-1:0]  job_col,
    output logic [FLT_W-1:0]  job_filt,
    output logic [NMULT-1:0]  unit_busy,
    output logic [CNT_W-1:0]  jobs_issued,
    output logic [CNT_W-1:0]  jobs_retired,
    output logic              busy,
    output logic              pass_done,
    output logic              err_spurious
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_JOB = CNT_W'(OUT_SIZE * OUT_SIZE * NF - 1);
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(OUT_SIZE - 1);

    state_t              state, state_n;
    logic                clear_pass;
    logic                xfer;
    logic [NMULT-1:0]    eligible;
    logic [2*NMULT-1:0]  elig2;
    logic [NMULT-1:0]    rot;
    logic [UNIT_W-1:0]   off;
    logic [UNIT_W:0]     sum;
    logic                found;
    logic [NMULT-1:0]    retire;
    logic [NMULT-1:0]    grant;
    logic [CNT_W-1:0]    retire_cnt;
    logic [UNIT_W-1:0]   rr_ptr;

`ifdef DISPATCH_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (job_unit == UNIT_W'(NMULT - 1)) ? '0 : job_unit + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

    // Rotate the eligible mask so bit 0 is the pointer position, then find the first set bit.
    assign eligible = ~unit_busy & ~unit_disable;
    assign elig2    = {eligible, eligible} >> rr_ptr;
    assign rot      = elig2[NMULT-1:0];

    always_comb begin
        found    = 1'b0;
        off      = '0;
        for (int i = 0; i < NMULT; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = UNIT_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (UNIT_W+1)'(NMULT))
            sum = sum - (UNIT_W+1)'(NMULT);
        job_unit  = sum[UNIT_W-1:0];
        job_valid = (state == ISSUE) && found;
    end

    assign xfer      = job_valid && job_ready;
    assign retire    = unit_done & unit_busy;
    assign grant     = xfer ? (NMULT'(1) << job_unit) : '0;
    assign busy      = (state != IDLE);
    assign pass_done = (state == DONE);

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NMULT; i++)
            retire_cnt = retire_cnt + CNT_W'(retire[i]);
    end

    always_comb begin
        state_n    = state;
        clear_pass = 1'b0;
        case (state)
            IDLE:  if (start && unit_busy == '0) begin
                       state_n    = ISSUE;
                       clear_pass = 1'b1;
                   end
            ISSUE: if (xfer && jobs_issued == LAST_JOB) state_n = DRAIN;
            DRAIN: if (unit_busy == '0) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n    = IDLE;
            clear_pass = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            job_row      <= '0;
            job_col      <= '0;
            job_filt     <= '0;
            unit_busy    <= '0;
            jobs_issued  <= '0;
            jobs_retired <= '0;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            // A retire and a grant can hit different units in the same cycle; both land.
            unit_busy    <= (unit_busy & ~retire) | grant;
            err_spurious <= err_spurious | (|(unit_done & ~unit_busy));
            if (clear_pass) begin
                job_row      <= '0;
                job_col      <= '0;
                job_filt     <= '0;
                jobs_issued  <= '0;
                jobs_retired <= '0;
            end else begin
                jobs_retired <= jobs_retired + retire_cnt;
                if (xfer) begin
                    jobs_issued <= jobs_issued + 1'b1;
                    if (job_col == CRD_MAX) begin
                        job_col <= '0;
                        if (job_row == CRD_MAX) begin
                            job_row  <= '0;
                            job_filt <= job_filt + 1'b1;
                        end else begin
                            job_row <= job_row + 1'b1;
                        end
                    end else begin
                        job_col <= job_col + 1'b1;
                    end
                end
            end
        end
    end
endmodule
